rgb2gray_pixel_pipe: RTL and testbench



---
 rtl/rgb2gray_pixel_pipe_if.sv | 14 +
 rtl/rgb2gray_pixel_pipe.sv | 150 +++++++++++++++
 tb/tb_rgb2gray_pixel_pipe.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb2gray_pixel_pipe_if.sv
// AXI4-Stream bundle for the rgb2gray pixel pipe. The master drives data, valid and
// sideband; the slave drives tready.
interface rgb2gray_pixel_pipe_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/rgb2gray_pixel_pipe.sv
// Streaming RGB->gray luma stage: 3-stage elastic pipe (products, sum, round/saturate).
// Define GRAY_REPLICATE_EN to widen m_axis.tdata to {gray,gray,gray}.

// One colour channel: 8-bit component times its Q0.22 weight, registered.
module rgb2gray_lane #(
    parameter int                VEC_W  = 8,
    parameter int                COEF_W = 22,
    parameter logic [COEF_W-1:0] COEF   = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ld,
    input  logic [VEC_W-1:0]          pix,
    output logic [VEC_W+COEF_W-1:0]   prod
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prod <= '0;
        else if (ld)
            prod <= {{COEF_W{1'b0}}, pix} * {{VEC_W{1'b0}}, COEF};
    end
endmodule

module rgb2gray_pixel_pipe #(
    parameter logic [21:0] COEF_R = 22'd1254097,
    parameter logic [21:0] COEF_G = 22'd2462056,
    parameter logic [21:0] COEF_B = 22'd478151
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    rgb2gray_pixel_pipe_if.slave  s_axis,
    rgb2gray_pixel_pipe_if.master m_axis
);
    localparam int NUM_LANES = 3;
    localparam int VEC_W     = 8;
    localparam int COEF_W    = 22;
    localparam int PROD_W    = VEC_W + COEF_W;
    localparam int SUM_W     = 32;
    localparam int STAGES    = 3;

    // Lane index matches the byte position in tdata: 0=B, 1=G, 2=R.
    localparam logic [NUM_LANES-1:0][COEF_W-1:0] COEF = {COEF_R, COEF_G, COEF_B};

    typedef struct packed {
        logic user;
        logic last;
    } side_t;

    logic [STAGES:1]                     vld_q;
    logic [STAGES:0]                     vld_pipe;
    logic [STAGES+1:1]                   rdy;
    logic [STAGES:1]                     ld;
    side_t [STAGES:1]                    side_q;
    side_t [STAGES:0]                    side_d;
    logic [NUM_LANES-1:0][PROD_W-1:0]    prod;
    logic [SUM_W-1:0]                    sum_d;
    logic [SUM_W-1:0]                    sum_q;
    logic [SUM_W:0]                      rnd_sum;
    logic [SUM_W-COEF_W:0]               rnd;
    logic [VEC_W-1:0]                    gray_d;
    logic [VEC_W-1:0]                    gray_q;
    logic                                unused_rnd_lsb;

    assign vld_pipe = {vld_q, s_axis.tvalid};

    // Ready ripples back from the sink; an empty stage always accepts.
    always_comb begin
        rdy              = '0;
        rdy[STAGES+1]    = m_axis.tready;
        for (int i = STAGES; i >= 1; i--)
            rdy[i] = !vld_q[i] || rdy[i+1];
    end

    always_comb begin
        side_d    = '0;
        side_d[0] = '{user: s_axis.tuser, last: s_axis.tlast};
        ld        = '0;
        for (int i = 1; i <= STAGES; i++) begin
            side_d[i] = side_q[i];
            ld[i]     = rdy[i] && vld_pipe[i-1];
        end
    end

    assign s_axis.tready = rdy[1];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_q  <= '0;
            side_q <= '0;
        end else begin
            for (int i = 1; i <= STAGES; i++) begin
                if (rdy[i])
                    vld_q[i] <= vld_pipe[i-1];
                if (ld[i])
                    side_q[i] <= side_d[i-1];
            end
        end
    end

    // S1: per-channel products.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        rgb2gray_lane #(
            .VEC_W  (VEC_W),
            .COEF_W (COEF_W),
            .COEF   (COEF[l])
        ) u_lane (
            .clk   (ap_clk),
            .rst_n (ap_rst_n),
            .ld    (ld[1]),
            .pix   (s_axis.tdata[l*VEC_W +: VEC_W]),
            .prod  (prod[l])
        );
    end

    // S2: sum of products; three 30-bit terms cannot overflow 32 bits.
    always_comb begin
        sum_d = '0;
        for (int l = 0; l < NUM_LANES; l++)
            sum_d = sum_d + {{(SUM_W-PROD_W){1'b0}}, prod[l]};
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            sum_q <= '0;
        else if (ld[2])
            sum_q <= sum_d;
    end

    // S3: round half-up at bit 21, then clamp to 8 bits.
    assign rnd_sum        = {1'b0, sum_q} + (33'd1 << (COEF_W - 1));
    assign rnd            = rnd_sum[SUM_W:COEF_W];
    assign unused_rnd_lsb = ^rnd_sum[COEF_W-1:0];
    assign gray_d         = (|rnd[SUM_W-COEF_W:VEC_W]) ? {VEC_W{1'b1}} : rnd[VEC_W-1:0];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            gray_q <= '0;
        else if (ld[3])
            gray_q <= gray_d;
    end

    assign m_axis.tvalid = vld_q[STAGES];
    assign m_axis.tuser  = side_q[STAGES].user;
    assign m_axis.tlast  = side_q[STAGES].last;
`ifdef GRAY_REPLICATE_EN
    assign m_axis.tdata  = {gray_q, gray_q, gray_q};
`else
    assign m_axis.tdata  = gray_q;
`endif
endmodule

// File: tb/tb_rgb2gray_pixel_pipe.sv
// Bench for rgb2gray_pixel_pipe: vector table, line/stall/reset sequences and a random
// run scored against an arithmetic luma model.
module tb_rgb2gray_pixel_pipe;
`ifdef GRAY_REPLICATE_EN
    localparam int OUT_W = 24;
`else
    localparam int OUT_W = 8;
`endif
    localparam longint CR = 1254097, CG = 2462056, CB = 478151, CMAX = 4194303;

    typedef struct {
        logic [23:0] px;
        logic [7:0]  exp;
    } vec_t;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             u;
        logic             l;
    } beat_t;

    logic ap_clk, ap_rst_n;
    int   n_cmp, n_err, cyc, mode;
    beat_t q[$];
    bit   line_mode;
    int   line_out, first_cyc, last_cyc;
    vec_t tbl[6];

    rgb2gray_pixel_pipe_if #(.DATA_W(24))    s_if ();
    rgb2gray_pixel_pipe_if #(.DATA_W(OUT_W)) m_if ();
    rgb2gray_pixel_pipe_if #(.DATA_W(24))    s2_if ();
    rgb2gray_pixel_pipe_if #(.DATA_W(OUT_W)) m2_if ();

    rgb2gray_pixel_pipe dut (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s_axis(s_if), .m_axis(m_if));
    rgb2gray_pixel_pipe #(.COEF_R(22'd4194303), .COEF_G(22'd4194303), .COEF_B(22'd4194303))
        dut_max (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s_axis(s2_if), .m_axis(m2_if));

    initial begin
        ap_clk = 0;
        forever #5 ap_clk = ~ap_clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge ap_clk);
            cyc = cyc + 1;
        end
    end

    function automatic logic [OUT_W-1:0] rep(input logic [7:0] g);
`ifdef GRAY_REPLICATE_EN
        return {g, g, g};
`else
        return g;
`endif
    endfunction

    // Luma = round(weighted sum / 2^22), clamped to 255.
    function automatic logic [OUT_W-1:0] model(input logic [23:0] px, input longint cr, input longint cg, input longint cb);
        longint s, r;
        logic [7:0] g;
        s = longint'(px[23:16]) * cr + longint'(px[15:8]) * cg + longint'(px[7:0]) * cb;
        r = (s + 64'd2097152) / 64'd4194304;
        if (r > 255) r = 255;
        g = r[7:0];
        return rep(g);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Sink-side tready generator: 0 = always ready, 1 = random 50%, 2 = stalled.
    initial begin
        m_if.tready = 0;
        m2_if.tready = 1;
        forever begin
            @(posedge ap_clk);
            #1;
            case (mode)
                0:       m_if.tready = 1;
                1:       m_if.tready = 1'($urandom_range(0, 1));
                default: m_if.tready = 0;
            endcase
        end
    end

    // Scoreboard + stall-stability monitor, sampled at the falling edge.
    initial begin
        bit stalled;
        logic [OUT_W-1:0] hd;
        logic hu, hl;
        beat_t e;
        stalled = 0;
        hd = '0; hu = 0; hl = 0;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                stalled = 0;
                q.delete();
            end else begin
                if (stalled) begin
                    chk("stall_valid", 32'(m_if.tvalid), 32'd1);
                    chk("stall_data", 32'(m_if.tdata), 32'(hd));
                    chk("stall_side", {30'd0, m_if.tuser, m_if.tlast}, {30'd0, hu, hl});
                end
                if (s_if.tvalid && s_if.tready)
                    q.push_back('{d: model(s_if.tdata, CR, CG, CB), u: s_if.tuser, l: s_if.tlast});
                if (m_if.tvalid && m_if.tready) begin
                    if (q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL extra_beat: got data %0h expected no beat", m_if.tdata);
                    end else begin
                        e = q.pop_front();
                        chk("out_data", 32'(m_if.tdata), 32'(e.d));
                        chk("out_side", {30'd0, m_if.tuser, m_if.tlast}, {30'd0, e.u, e.l});
                    end
                    if (line_mode) begin
                        if (line_out == 0) first_cyc = cyc;
                        last_cyc = cyc;
                        line_out++;
                    end
                end
                stalled = m_if.tvalid && !m_if.tready;
                hd = m_if.tdata; hu = m_if.tuser; hl = m_if.tlast;
            end
        end
    end

    task automatic send(input logic [23:0] px, input logic u, input logic l);
        bit acc;
        int t;
        s_if.tdata = px; s_if.tuser = u; s_if.tlast = l; s_if.tvalid = 1;
        t = 0;
        forever begin
            @(negedge ap_clk);
            acc = s_if.tready;
            @(posedge ap_clk);
            #1;
            if (acc) break;
            if (++t > 2000) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout: got no tready expected accept");
                break;
            end
        end
        s_if.tvalid = 0; s_if.tuser = 0; s_if.tlast = 0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 5000) begin
            @(negedge ap_clk);
            t++;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
        repeat (2) @(posedge ap_clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

    initial begin
        int acc;
        tbl[0] = '{24'hFF0000, 8'd76};
        tbl[1] = '{24'h00FF00, 8'd150};
        tbl[2] = '{24'h0000FF, 8'd29};
        tbl[3] = '{24'hFFFFFF, 8'd255};
        tbl[4] = '{24'h808080, 8'd128};
        tbl[5] = '{24'h000000, 8'd0};
        n_cmp = 0; n_err = 0; mode = 0;
        line_mode = 0; line_out = 0; first_cyc = 0; last_cyc = 0;
        ap_rst_n = 0;
        s_if.tdata = '0; s_if.tvalid = 0; s_if.tuser = 0; s_if.tlast = 0;
        s2_if.tdata = '0; s2_if.tvalid = 0; s2_if.tuser = 0; s2_if.tlast = 0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_mvalid", 32'(m_if.tvalid), 32'd0);
        chk("rst_mdata", 32'(m_if.tdata), 32'd0);
        chk("rst_mside", {30'd0, m_if.tuser, m_if.tlast}, 32'd0);
        next_cycle();
        ap_rst_n = 1;
        @(negedge ap_clk);
        chk("rst_sready", 32'(s_if.tready), 32'd1);
        next_cycle();

        // Single beats: valid exactly three edges after acceptance.
        foreach (tbl[i]) begin
            send(tbl[i].px, 0, 0);
            @(negedge ap_clk);
            chk("lat_e1_valid", 32'(m_if.tvalid), 32'd0);
            @(negedge ap_clk);
            chk("lat_e2_valid", 32'(m_if.tvalid), 32'd0);
            @(negedge ap_clk);
            chk("lat_e3_valid", 32'(m_if.tvalid), 32'd1);
            chk("tbl_gray", 32'(m_if.tdata), 32'(rep(tbl[i].exp)));
            next_cycle();
        end
        drain();

        // 640-pixel line, back to back.
        line_mode = 1; line_out = 0;
        for (int i = 0; i < 640; i++)
            send(24'($urandom), i == 0, i == 639);
        drain();
        line_mode = 0;
        chk("line_count", 32'(line_out), 32'd640);
        chk("line_span", 32'(last_cyc - first_cyc), 32'd639);

        // Stall with a full pipe: exactly three beats go in.
        mode = 2;
        next_cycle();
        next_cycle();
        acc = 0;
        s_if.tdata = 24'($urandom); s_if.tvalid = 1;
        for (int k = 0; k < 6; k++) begin
            bit took;
            @(negedge ap_clk);
            took = s_if.tready;
            if (took) acc++;
            next_cycle();
            if (took) s_if.tdata = 24'($urandom);
        end
        chk("stall_accepts", 32'(acc), 32'd3);
        @(negedge ap_clk);
        chk("stall_sready", 32'(s_if.tready), 32'd0);
        mode = 0;
        next_cycle();
        m_if.tready = 1;
        for (int k = 0; k < 6; k++) begin
            bit took;
            @(negedge ap_clk);
            chk("resume_mvalid", 32'(m_if.tvalid), 32'd1);
            chk("resume_sready", 32'(s_if.tready), 32'd1);
            took = s_if.tready;
            next_cycle();
            if (took) s_if.tdata = 24'($urandom);
        end
        s_if.tvalid = 0;
        drain();

        // Reset with the pipe full.
        mode = 2;
        next_cycle();
        for (int i = 0; i < 3; i++)
            send(24'($urandom), 0, 0);
        @(negedge ap_clk);
        chk("prerst_mvalid", 32'(m_if.tvalid), 32'd1);
        next_cycle();
        ap_rst_n = 0;
        #1;
        chk("rst_async_mvalid", 32'(m_if.tvalid), 32'd0);
        next_cycle();
        ap_rst_n = 1;
        mode = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge ap_clk);
            chk("postrst_no_beat", 32'(m_if.tvalid), 32'd0);
        end
        next_cycle();

        // Random pixels, random sideband, 50% sink stalls.
        mode = 1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) next_cycle();
            send(24'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        mode = 0;
        drain();

        // Full-scale coefficients: saturation and smallest nonzero output.
        for (int i = 0; i < 2; i++) begin
            logic [23:0] px;
            px = (i == 0) ? 24'hFFFFFF : 24'h010000;
            s2_if.tdata = px; s2_if.tvalid = 1;
            @(negedge ap_clk);
            chk("max_sready", 32'(s2_if.tready), 32'd1);
            next_cycle();
            s2_if.tvalid = 0;
            repeat (2) @(posedge ap_clk);
            @(negedge ap_clk);
            chk("max_mvalid", 32'(m2_if.tvalid), 32'd1);
            chk("max_gray", 32'(m2_if.tdata), 32'(model(px, CMAX, CMAX, CMAX)));
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
